// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory data-port arbiter: FSM encoding, wait-counter width
// and the captured debug request.
package mem_arb_pkg;

    localparam int ARB_WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DBG_ACC  = 2'd1,
        DBG_RESP = 2'd2,
        DBG_GAP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } dbg_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between CPU datapath, debug requester, data memory and the arbiter.
// slave = arbiter side, master = everything around it.
interface mem_port_arbiter_if;

    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_stall;

    logic       dbg_req;
    logic       dbg_we;
    logic [7:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_gnt;
    logic       dbg_rvalid;
    logic [7:0] dbg_rdata;

    logic       mem_rd;
    logic       mem_wren;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] mem_q;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_q,
        output cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_rd, mem_wren, mem_addr, mem_data
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_q,
        input  cpu_stall, dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_rd, mem_wren, mem_addr, mem_data
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Saturating up-counter with synchronous clear; tracks how long a debug request
// has been denied. Used only when MEM_ARB_FAIRNESS_EN is defined.
module arb_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int W = ARB_WAIT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data port of the dual-port memory between the multicycle CPU and a
// debug/loader requester, stalling the CPU during debug accesses. Option: MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [ARB_WAIT_W-1:0] STARVE_THR = ARB_WAIT_W'(STARVE_LIMIT);

    arb_state_e            state, state_nx;
    dbg_req_t              lat;
    logic [7:0]            rdata_hold;
    logic [ARB_WAIT_W-1:0] wait_cnt;
    logic                  in_idle, starve, grant;

    assign in_idle = (state == IDLE);
    assign starve  = (wait_cnt >= STARVE_THR);
    // cpu_rd always blocks: the MDR loads mem_q in the following cycle.
    assign grant   = in_idle & bus.dbg_req & ~bus.cpu_rd & (~bus.cpu_wr | starve);

`ifdef MEM_ARB_FAIRNESS_EN
    logic wait_clr, wait_inc;

    assign wait_clr = ~bus.dbg_req | grant;
    assign wait_inc = in_idle & bus.dbg_req & ~grant;

    arb_wait_counter #(.W(ARB_WAIT_W)) u_wait_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .count (wait_cnt)
    );
`else
    // Without fairness the count never moves, so starve folds to 0.
    assign wait_cnt = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (grant) state_nx = DBG_ACC;
            DBG_ACC:  state_nx = lat.we ? DBG_GAP : DBG_RESP;
            DBG_RESP: state_nx = DBG_GAP;
            DBG_GAP:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lat <= '0;
        else if (grant)
            lat <= '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rdata_hold <= '0;
        else if (state == DBG_RESP)
            rdata_hold <= bus.mem_q;
    end

    always_comb begin
        bus.mem_rd     = bus.cpu_rd;
        bus.mem_wren   = bus.cpu_wr;
        bus.mem_addr   = bus.cpu_addr;
        bus.mem_data   = bus.cpu_wdata;
        bus.cpu_stall  = 1'b0;
        bus.dbg_gnt    = 1'b0;
        bus.dbg_rvalid = 1'b0;
        bus.dbg_rdata  = rdata_hold;
        case (state)
            DBG_ACC: begin
                bus.cpu_stall = 1'b1;
                bus.dbg_gnt   = 1'b1;
                bus.mem_addr  = lat.addr;
                bus.mem_wren  = lat.we;
                bus.mem_rd    = ~lat.we;
                bus.mem_data  = lat.wdata;
            end
            DBG_RESP: begin
                // mem_q now reflects the address presented in DBG_ACC.
                bus.cpu_stall  = 1'b1;
                bus.dbg_rvalid = 1'b1;
                bus.dbg_rdata  = bus.mem_q;
                bus.mem_rd     = 1'b0;
                bus.mem_wren   = 1'b0;
                bus.mem_addr   = lat.addr;
                bus.mem_data   = lat.wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// stalls and read data; a negedge monitor compares the DUT every cycle.
module tb_mem_port_arbiter;

    localparam int SL = 3;

    typedef struct {
        int         cyc;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Data memory: registered read, write on the edge.
    logic [7:0] pmem [256];
    always @(posedge clock) begin
        if (bus.mem_wren) pmem[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= pmem[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic [7:0] ref_mem [256];
    bit         stall_set [int];
    ev_t        gnt_q [$];
    ev_t        rv_q [$];
    ev_t        rd_q [$];
    int         free_cyc = 0;
    int         wait_n = 0;
    logic [7:0] exp_hold = 8'h00;
    bit         in_reset = 1'b1;
    bit         started = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_pass(input string nm);
        chk1({nm, "_rd"}, bus.mem_rd, bus.cpu_rd);
        chk1({nm, "_wren"}, bus.mem_wren, bus.cpu_wr);
        chk8({nm, "_addr"}, bus.mem_addr, bus.cpu_addr);
        chk8({nm, "_data"}, bus.mem_data, bus.cpu_wdata);
    endtask

    // One cycle of stimulus plus the model's view of what the arbiter must do with it.
    task automatic drive(input logic c_rd, input logic c_wr, input logic [7:0] c_addr,
                         input logic [7:0] c_wd, input logic d_req, input logic d_we,
                         input logic [7:0] d_addr, input logic [7:0] d_wd, output logic gr);
        bit stalled, idle, starve;
        @(posedge clock);
        #2;
        bus.cpu_rd = c_rd;   bus.cpu_wr = c_wr;   bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
        bus.dbg_req = d_req; bus.dbg_we = d_we;   bus.dbg_addr = d_addr; bus.dbg_wdata = d_wd;
        stalled = stall_set.exists(cyc) != 0;
        idle    = cyc >= free_cyc;
`ifdef MEM_ARB_FAIRNESS_EN
        starve = wait_n >= SL;
`else
        starve = 1'b0;
`endif
        gr = idle && d_req && !c_rd && (!c_wr || starve);
        if (!stalled && c_wr) ref_mem[c_addr] = c_wd;
        if (!stalled && c_rd) rd_q.push_back('{cyc: cyc + 1, we: 1'b0, addr: c_addr, data: ref_mem[c_addr]});
        if (!d_req || gr) wait_n = 0;
        else if (idle && wait_n < 15) wait_n++;
        if (gr) begin
            free_cyc = cyc + (d_we ? 3 : 4);
            stall_set[cyc + 1] = 1'b1;
            gnt_q.push_back('{cyc: cyc + 1, we: d_we, addr: d_addr, data: d_wd});
            if (d_we) ref_mem[d_addr] = d_wd;
            else begin
                stall_set[cyc + 2] = 1'b1;
                rv_q.push_back('{cyc: cyc + 2, we: 1'b0, addr: d_addr, data: ref_mem[d_addr]});
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        logic g;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_reset = 1'b1;
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 8'h77; bus.cpu_wdata = 8'h3C;
        bus.dbg_req = 1'b0;
        #1;
        chk1("rst_stall", bus.cpu_stall, 1'b0);
        chk1("rst_gnt", bus.dbg_gnt, 1'b0);
        chk1("rst_rvalid", bus.dbg_rvalid, 1'b0);
        chk8("rst_rdata", bus.dbg_rdata, 8'h00);
        chk_pass("rst_pass");
        stall_set.delete();
        gnt_q.delete(); rv_q.delete(); rd_q.delete();
        free_cyc = 0; wait_n = 0; exp_hold = 8'h00;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        in_reset = 1'b0;
    endtask

    // Monitor / scoreboard.
    always @(negedge clock) begin
        if (started && !in_reset) begin
            ev_t e;
            bit  exp_stall;
            exp_stall = stall_set.exists(cyc) != 0;
            chk1("cpu_stall", bus.cpu_stall, exp_stall);
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                e = gnt_q.pop_front();
                chk1("dbg_gnt", bus.dbg_gnt, 1'b1);
                chk8("acc_addr", bus.mem_addr, e.addr);
                chk1("acc_wren", bus.mem_wren, e.we);
                chk1("acc_rd", bus.mem_rd, !e.we);
                if (e.we) chk8("acc_data", bus.mem_data, e.data);
            end else
                chk1("dbg_gnt", bus.dbg_gnt, 1'b0);
            if (rv_q.size() > 0 && rv_q[0].cyc == cyc) begin
                e = rv_q.pop_front();
                chk1("dbg_rvalid", bus.dbg_rvalid, 1'b1);
                chk8("dbg_rdata", bus.dbg_rdata, e.data);
                chk1("resp_rd", bus.mem_rd, 1'b0);
                chk1("resp_wren", bus.mem_wren, 1'b0);
                exp_hold = e.data;
            end else begin
                chk1("dbg_rvalid", bus.dbg_rvalid, 1'b0);
                chk8("rdata_hold", bus.dbg_rdata, exp_hold);
            end
            if (!exp_stall) chk_pass("pass");
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                chk8("cpu_mdr", bus.mem_q, e.data);
            end
        end
    end

    initial begin
        logic       g, pend, d_we;
        logic [7:0] d_addr, d_wd, v;
        int         r;

        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            pmem[i] = v;
            ref_mem[i] = v;
        end
        pmem[8'h33] = 8'hC4;
        ref_mem[8'h33] = 8'hC4;

        // Reset state with the CPU presenting a read.
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 8'h44; bus.cpu_wdata = 8'h11;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00; bus.dbg_wdata = 8'h00;
        #1;
        chk1("init_stall", bus.cpu_stall, 1'b0);
        chk1("init_gnt", bus.dbg_gnt, 1'b0);
        chk1("init_rvalid", bus.dbg_rvalid, 1'b0);
        chk8("init_rdata", bus.dbg_rdata, 8'h00);
        chk_pass("init_pass");
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        in_reset = 1'b0;
        started = 1'b1;

        // Debug write 0x20 <- 0x5A, then the CPU reads it back.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h5A, g);
        idle_cycles(2);
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, g);
        idle_cycles(2);

        // Debug read of preloaded 0x33.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00, g);
        idle_cycles(4);

        // Reset landing in DBG_RESP.
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00, g);
        idle_cycles(1);
        @(posedge clock);
        #1;
        chk1("pre_rst_rvalid", bus.dbg_rvalid, 1'b1);
        chk1("pre_rst_stall", bus.cpu_stall, 1'b1);
        do_reset();
        idle_cycles(1);

        // cpu_rd blocks the grant; next idle CPU cycle grants.
        drive(1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, g);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, g);
        idle_cycles(4);

        // Three back-to-back writes with dbg_req held high.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 8; t++) begin
                drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'(8'h40 + k), 8'(k * 17 + 3), g);
                if (g) break;
            end
        end
        idle_cycles(3);
        drive(1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, g);
        idle_cycles(2);

        // CPU keeps writing while debug waits: starvation relief only with fairness.
        pend = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 8'h50, 8'hAA, pend, 1'b1, 8'h60, 8'h99, g);
            if (g) pend = 1'b0;
        end
        idle_cycles(4);

        // Randomized traffic.
        pend = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wd = 8'h00;
        for (int i = 0; i < 800; i++) begin
            logic c_rd, c_wr;
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                d_we = 1'($urandom);
                d_addr = 8'($urandom_range(0, 15));
                d_wd = 8'($urandom);
            end else if (pend && $urandom_range(0, 19) == 0)
                pend = 1'b0;
            r = $urandom_range(0, 3);
            c_rd = (r == 2);
            c_wr = (r == 3);
            drive(c_rd, c_wr, 8'($urandom_range(0, 15)), 8'($urandom), pend, d_we, d_addr, d_wd, g);
            if (g) pend = 1'b0;
        end
        idle_cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
